prog_fetch: RTL and testbench
=============================

PROG_FETCH -- requirements
Module: prog_fetch

Interface
REQ-001 Parameter DATA_W, default 12: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width; memory depth SHALL be 2**ADDR_W words.
REQ-003 Parameter RESET_PC, default 0: PC value after reset.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  IDLE->RUN request.
REQ-008 halt  in  1  RUN->IDLE request.
REQ-009 stall  in  1  freezes fetch in RUN.
REQ-010 jump  in  1  redirect PC to jump_addr.
REQ-011 jump_addr  in  ADDR_W  redirect target.
REQ-012 ld_req  in  1  IDLE->LOAD request.
REQ-013 ld_valid  in  1  load word present.
REQ-014 ld_addr  in  ADDR_W  load write address.
REQ-015 ld_data  in  DATA_W  load write data.
REQ-016 ld_last  in  1  marks final load word.
REQ-017 ld_ready  out  1  high only in LOAD.
REQ-018 pc  out  ADDR_W  next fetch address.
REQ-019 instr  out  DATA_W  registered fetched instruction.
REQ-020 instr_pc  out  ADDR_W  address instr was fetched from.
REQ-021 instr_valid  out  1  instr holds a fresh fetch this cycle.
REQ-022 state  out  2  IDLE=0, LOAD=1, RUN=2; 3 unused.

Function
REQ-023 Storage: 2**ADDR_W x DATA_W array; contents SHALL NOT be reset.
REQ-024 IDLE: ld_req -> LOAD; else start -> RUN; ld_req SHALL win when both are high; jump in IDLE SHALL load pc<=jump_addr, and with start asserted the run begins at jump_addr.
REQ-025 LOAD: ld_ready=1; ld_valid&ld_ready SHALL write mem[ld_addr]<=ld_data that edge; handshake with ld_last -> IDLE next cycle; start, jump, stall, halt ignored.
REQ-026 RUN, no stall, no jump: instr<=mem[pc], instr_pc<=pc, instr_valid<=1, pc<=pc+1 modulo 2**ADDR_W (all-ones wraps to 0); fetch latency one cycle.
REQ-027 RUN, jump=1: pc<=jump_addr, instr_valid<=0 (flush), instr/instr_pc held; jump SHALL take priority over stall.
REQ-028 RUN, stall=1, jump=0: pc, instr, instr_pc held; instr_valid<=0.
REQ-029 RUN, halt=1: -> IDLE, instr_valid<=0, pc held; halt SHALL take priority over jump and stall.
REQ-030 Unused state 3 SHALL return to IDLE next cycle with instr_valid=0.
REQ-031 ld_ready SHALL be 0 outside LOAD; memory writes SHALL occur only in LOAD.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, ld_ready=0, par_err=0 (if present).
REQ-033 Reset mid-LOAD SHALL abort without writing the word presented in that cycle; previously written words SHALL be retained.

Configuration
REQ-034 Macro PROG_FETCH_PARITY_EN defined: each word SHALL store an extra even-parity bit computed on load; output par_err (1 bit) SHALL be registered high in the cycle instr_valid rises with a word whose parity mismatches, and cleared on the next valid fetch with correct parity or reset.
REQ-035 Macro undefined: no parity storage, no par_err port; all other behaviour identical.

Verification
REQ-036 Load 0xA01@0x00, 0xB02@0x01, 0xC03@0xFF (ld_last on third), start -> instr 0xA01/pc0 then 0xB02/pc1 on consecutive cycles, ld_ready=0 in RUN.
REQ-037 RUN at pc=0xFF -> instr=0xC03, instr_pc=0xFF, next pc=0x00 (wrap).
REQ-038 jump=1, jump_addr=0x10, stall=1 same cycle -> pc=0x10, instr_valid=0; next unstalled cycle instr_pc=0x10.
REQ-039 start and ld_req together in IDLE -> state=LOAD, ld_ready=1; halt in RUN -> state=IDLE, pc held.
REQ-040 rst pulse mid-LOAD during word 0x5A5@0x20 -> state=IDLE, pc=RESET_PC, mem[0x20] unchanged.
REQ-041 With PROG_FETCH_PARITY_EN, force one flipped stored bit @0x03 -> par_err=1 when instr_pc=0x03, 0 on next clean fetch.

Source files
------------

// File: rtl/prog_fetch_if.sv
// Bus bundle between a host/loader and prog_fetch.
// par_err exists only when PROG_FETCH_PARITY_EN is defined.
interface prog_fetch_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              halt;
  logic              stall;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              ld_req;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic [1:0]        state;
`ifdef PROG_FETCH_PARITY_EN
  logic              par_err;
`endif

  modport master (
    output start, halt, stall, jump, jump_addr,
    output ld_req, ld_valid, ld_addr, ld_data, ld_last,
    input  ld_ready, pc, instr, instr_pc, instr_valid, state
`ifdef PROG_FETCH_PARITY_EN
    , input par_err
`endif
  );

  modport slave (
    input  start, halt, stall, jump, jump_addr,
    input  ld_req, ld_valid, ld_addr, ld_data, ld_last,
    output ld_ready, pc, instr, instr_pc, instr_valid, state
`ifdef PROG_FETCH_PARITY_EN
    , output par_err
`endif
  );
endinterface

// File: rtl/prog_fetch.sv
// Program memory with loader and sequential instruction fetch.
// Define PROG_FETCH_PARITY_EN to add a per-word even-parity bit and par_err.
//
// state | meaning
// IDLE  | waiting for ld_req (load) or start (run); jump sets pc
// LOAD  | ld_ready high, words written on ld_valid, ld_last ends
// RUN   | one fetch per unstalled cycle; halt/jump/stall in that priority
// BAD   | unused encoding, falls back to IDLE
module prog_fetch #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input logic      clk,
  input logic      rst,
  prog_fetch_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_BAD  = 2'd3
  } state_t;

`ifdef PROG_FETCH_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  r_mem [2**ADDR_W];
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, r_instr_pc;
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;
  logic              w_fetch, w_wr;
  logic [MEM_W-1:0]  w_wr_word, w_rd_word;

`ifdef PROG_FETCH_PARITY_EN
  logic r_par_err;
  assign w_wr_word = {^bus.ld_data, bus.ld_data};
  assign bus.par_err = r_par_err;
`else
  assign w_wr_word = bus.ld_data;
`endif

  // rst gates the write so a reset overlapping an edge cannot commit a word
  assign w_wr      = (r_state == S_LOAD) && bus.ld_valid && !rst;
  assign w_rd_word = r_mem[r_pc];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[bus.ld_addr] <= w_wr_word;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fetch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.jump) w_pc_nxt = bus.jump_addr;
        if (bus.ld_req)     w_state_nxt = S_LOAD;
        else if (bus.start) w_state_nxt = S_RUN;
      end
      S_LOAD: begin
        if (bus.ld_valid && bus.ld_last) w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (bus.halt) begin
          w_state_nxt = S_IDLE;
        end else if (bus.jump) begin
          w_pc_nxt = bus.jump_addr;
        end else if (!bus.stall) begin
          w_fetch  = 1'b1;
          w_pc_nxt = r_pc + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= ADDR_W'(RESET_PC);
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
`ifdef PROG_FETCH_PARITY_EN
      r_par_err     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr_valid <= w_fetch;
      if (w_fetch) begin
        r_instr    <= w_rd_word[DATA_W-1:0];
        r_instr_pc <= r_pc;
`ifdef PROG_FETCH_PARITY_EN
        // stored bit makes the whole word XOR to zero when intact
        r_par_err  <= ^w_rd_word;
`endif
      end
    end
  end

  assign bus.ld_ready    = (r_state == S_LOAD);
  assign bus.pc          = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.state       = r_state;
endmodule

// File: tb/tb_prog_fetch.sv
// Scoreboard bench for prog_fetch: fetches are queued when issued and
// checked by a monitor whenever instr_valid is seen.
module tb_prog_fetch;
  localparam int DW = 12;
  localparam int AW = 8;
  localparam int RPC = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  prog_fetch #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW+AW-1:0] q[$];
  logic [DW-1:0] exp_mem [2**AW];
  logic [AW-1:0] pcm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    bus.ld_last  = last;
    exp_mem[a]   = d;
    step();
  endtask

  task automatic run_cycle();
    q.push_back({exp_mem[pcm], pcm});
    pcm = pcm + 1'b1;
    step();
  endtask

  // monitor: every valid fetch must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && bus.instr_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_fetch: got instr 0x%0h @0x%0h, none expected",
                 bus.instr, bus.instr_pc);
      end else begin
        logic [DW+AW-1:0] e;
        e = q.pop_front();
        chk("fetch_instr", 32'(bus.instr), 32'(e[DW+AW-1:AW]));
        chk("fetch_pc", 32'(bus.instr_pc), 32'(e[AW-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.halt = 0; bus.stall = 0; bus.jump = 0; bus.jump_addr = '0;
    bus.ld_req = 0; bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 0;
    pcm = AW'(RPC);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_pc", 32'(bus.pc), RPC);
    chk("rst_instr", 32'(bus.instr), 0);
    chk("rst_instr_pc", 32'(bus.instr_pc), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 0);
    rst = 1'b0;
    step();

    // ld_req beats start
    bus.ld_req = 1; bus.start = 1;
    step();
    bus.ld_req = 0; bus.start = 0;
    chk("ldreq_wins_state", 32'(bus.state), 1);
    chk("load_ld_ready", 32'(bus.ld_ready), 1);

    bus.start = 1;
    load_word(8'h10, 12'h110, 0);
    bus.start = 0;
    chk("load_ignores_start", 32'(bus.state), 1);
    load_word(8'h11, 12'h111, 0);
    load_word(8'h20, 12'h220, 0);
    load_word(8'h03, 12'h333, 0);
    load_word(8'h00, 12'hA01, 0);
    load_word(8'h01, 12'hB02, 0);
    load_word(8'hFF, 12'hC03, 1);
    bus.ld_valid = 0; bus.ld_last = 0;
    chk("ld_last_to_idle", 32'(bus.state), 0);
    chk("idle_ld_ready", 32'(bus.ld_ready), 0);

    bus.start = 1;
    step();
    bus.start = 0;
    chk("run_state", 32'(bus.state), 2);
    chk("run_ld_ready", 32'(bus.ld_ready), 0);
    run_cycle();
    run_cycle();
    chk("pc_after_two", 32'(bus.pc), 2);

    // halt beats jump and stall
    bus.halt = 1; bus.jump = 1; bus.jump_addr = 8'h55; bus.stall = 1;
    step();
    bus.halt = 0; bus.jump = 0; bus.stall = 0;
    chk("halt_state", 32'(bus.state), 0);
    chk("halt_pc_held", 32'(bus.pc), 2);
    chk("halt_valid", 32'(bus.instr_valid), 0);

    // jump with start in IDLE: run begins at 0xFF, then wraps
    bus.jump = 1; bus.jump_addr = 8'hFF; bus.start = 1;
    step();
    bus.jump = 0; bus.start = 0;
    chk("idle_jump_pc", 32'(bus.pc), 8'hFF);
    pcm = 8'hFF;
    run_cycle();
    chk("wrap_pc", 32'(bus.pc), 0);
    run_cycle();

    // jump beats stall
    bus.jump = 1; bus.jump_addr = 8'h10; bus.stall = 1;
    step();
    bus.jump = 0;
    chk("jump_stall_pc", 32'(bus.pc), 8'h10);
    chk("jump_flush_valid", 32'(bus.instr_valid), 0);
    chk("jump_instr_pc_held", 32'(bus.instr_pc), 0);
    step();
    bus.stall = 0;
    chk("stall_pc_held", 32'(bus.pc), 8'h10);
    chk("stall_valid", 32'(bus.instr_valid), 0);
    chk("stall_instr_held", 32'(bus.instr), 12'hA01);
    pcm = 8'h10;
    run_cycle();
    run_cycle();
    bus.halt = 1;
    step();
    bus.halt = 0;

    // reset in the middle of a LOAD cycle
    bus.ld_req = 1;
    step();
    bus.ld_req = 0;
    chk("reload_state", 32'(bus.state), 1);
    bus.ld_valid = 1; bus.ld_addr = 8'h20; bus.ld_data = 12'h5A5; bus.ld_last = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("midload_rst_state", 32'(bus.state), 0);
    chk("midload_rst_pc", 32'(bus.pc), RPC);
    chk("midload_rst_ready", 32'(bus.ld_ready), 0);
    step();
    bus.ld_valid = 0;
    rst = 1'b0;
    step();
    bus.jump = 1; bus.jump_addr = 8'h20; bus.start = 1;
    step();
    bus.jump = 0; bus.start = 0;
    pcm = 8'h20;
    run_cycle();
    bus.halt = 1;
    step();
    bus.halt = 0;

`ifdef PROG_FETCH_PARITY_EN
    dut.r_mem[8'h03][DW] = ~dut.r_mem[8'h03][DW];
    bus.jump = 1; bus.jump_addr = 8'h03; bus.start = 1;
    step();
    bus.jump = 0; bus.start = 0;
    pcm = 8'h03;
    run_cycle();
    chk("par_err_set", 32'(bus.par_err), 1);
    bus.jump = 1; bus.jump_addr = 8'h10;
    step();
    bus.jump = 0;
    chk("par_err_held_on_flush", 32'(bus.par_err), 1);
    pcm = 8'h10;
    run_cycle();
    chk("par_err_clear", 32'(bus.par_err), 0);
    bus.halt = 1;
    step();
    bus.halt = 0;
`endif

    step();
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
